// File: rtl/inv_add_round_key_stage.sv
// rtl/inv_add_round_key_stage.sv - registered AES inverse AddRoundKey stage with key store and round tagging
module inv_add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_wr_en,
    input  logic [5:0]   key_wr_addr,
    input  logic [0:31]  key_wr_data,
    output logic         key_wr_err,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] state_out,
    output logic [3:0]   out_round,
    output logic         out_last
);

    localparam int         NW   = 4 * (NR + 1);
    localparam logic [3:0] NR_L = 4'(NR);

    logic [0:31]  key_q [NW];
    logic [3:0]   rc_q, rc_d;
    logic         out_valid_q, out_valid_d;
    logic [0:127] state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic         err_q, err_d;

    logic         accept;
    logic         idle;
    logic         key_wr_ok;
    logic [5:0]   key_idx;
    logic [0:127] round_key;

    assign in_ready  = !abort && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign idle      = (rc_q == NR_L) && !out_valid_q;
    assign key_wr_ok = key_wr_en && idle && (key_wr_addr < 6'(NW));

    // Round key r occupies words 4r..4r+3; reads see contents before any same-cycle write.
    assign key_idx   = {rc_q, 2'b00};
    assign round_key = {key_q[key_idx], key_q[key_idx + 6'd1],
                        key_q[key_idx + 6'd2], key_q[key_idx + 6'd3]};

    always_comb begin
        rc_d        = rc_q;
        out_valid_d = out_valid_q;
        state_d     = state_q;
        round_d     = round_q;
        err_d       = key_wr_en && !key_wr_ok;
        if (abort) begin
            rc_d        = NR_L;
            out_valid_d = 1'b0;
        end else if (accept) begin
            state_d     = state_in ^ round_key;
            round_d     = rc_q;
            out_valid_d = 1'b1;
            rc_d        = (rc_q == 4'd0) ? NR_L : rc_q - 4'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_q        <= NR_L;
            out_valid_q <= 1'b0;
            state_q     <= '0;
            round_q     <= NR_L;
            err_q       <= 1'b0;
        end else begin
            rc_q        <= rc_d;
            out_valid_q <= out_valid_d;
            state_q     <= state_d;
            round_q     <= round_d;
            err_q       <= err_d;
        end
    end

    // Key store is cleared by reset so a mid-block reset cannot leak old key material.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) begin
                key_q[i] <= '0;
            end
        end else if (key_wr_ok) begin
            key_q[key_wr_addr] <= key_wr_data;
        end
    end

    assign out_valid  = out_valid_q;
    assign state_out  = state_q;
    assign out_round  = round_q;
    assign out_last   = (round_q == 4'd0);
    assign key_wr_err = err_q;

endmodule

// File: tb/tb_inv_add_round_key_stage.sv
// tb/tb_inv_add_round_key_stage.sv - self-checking bench for inv_add_round_key_stage
module tb_inv_add_round_key_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_wr_en;
    logic [5:0]   key_wr_addr;
    logic [0:31]  key_wr_data;
    logic         key_wr_err;
    logic         abort;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] state_out;
    logic [3:0]   out_round;
    logic         out_last;

    always #5 clk = ~clk;

    inv_add_round_key_stage #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
        .key_wr_err(key_wr_err), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .state_in(state_in),
        .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out),
        .out_round(out_round), .out_last(out_last)
    );

    int checks   = 0;
    int failures = 0;

    logic [0:127] rk_fips [11];
    logic [0:31]  mk [44];
    int           model_rc;

    typedef struct {
        logic [0:127] din;
        logic [0:127] dout;
        int           rnd;
        logic         last;
    } vec_t;
    vec_t tv [11];

    typedef struct {
        logic [0:127] d;
        int           r;
    } exp_t;
    exp_t q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:127] mrk(input int r);
        return {mk[4*r], mk[4*r+1], mk[4*r+2], mk[4*r+3]};
    endfunction

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept one state and check the registered result against the model key store.
    task automatic send(input logic [0:127] x, input int r, input string tag);
        in_valid = 1'b1;
        state_in = x;
        tick();
        in_valid = 1'b0;
        chk({tag, "_valid"}, 128'(out_valid), 128'(1));
        chk({tag, "_data"},  state_out, x ^ mrk(r));
        chk({tag, "_round"}, 128'(out_round), 128'(r));
        chk({tag, "_last"},  128'(out_last), 128'(r == 0));
    endtask

    task automatic key_write(input int addr, input logic [0:31] data, input bit commit);
        key_wr_en   = 1'b1;
        key_wr_addr = 6'(addr);
        key_wr_data = data;
        if (commit) mk[addr] = data;
    endtask

    initial begin
        logic [0:127] t;
        logic [0:127] y;
        logic [0:127] x;
        logic [0:127] old_rk10;

        rk_fips[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_fips[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk_fips[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk_fips[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk_fips[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk_fips[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk_fips[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk_fips[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk_fips[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk_fips[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk_fips[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        tv[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h7ad5fda789ef4e272bca100b3d9ff59f, 10, 1'b0};
        for (int i = 1; i < 10; i++) begin
            tv[i].din  = rnd128();
            tv[i].dout = tv[i].din ^ rk_fips[10-i];
            tv[i].rnd  = 10 - i;
            tv[i].last = 1'b0;
        end
        tv[10] = '{128'h00102030405060708090a0b0c0d0e0f0,
                   128'h00112233445566778899aabbccddeeff, 0, 1'b1};

        for (int i = 0; i < 44; i++) mk[i] = '0;
        rst_n = 1'b0; key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0;
        abort = 1'b0; in_valid = 1'b0; state_in = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_state_out", state_out, 128'(0));
        chk("rst_out_round", 128'(out_round), 128'(10));
        chk("rst_out_last",  128'(out_last), 128'(0));
        chk("rst_key_wr_err", 128'(key_wr_err), 128'(0));
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 11; r++) begin
            t = rk_fips[r];
            for (int j = 0; j < 4; j++) begin
                key_write(4*r + j, t[32*j +: 32], 1'b1);
                tick();
                chk("load_err", 128'(key_wr_err), 128'(0));
            end
        end
        key_wr_en = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            state_in = tv[i].din;
            tick();
            in_valid = 1'b0;
            chk("tv_valid", 128'(out_valid), 128'(1));
            chk("tv_data",  state_out, tv[i].dout);
            chk("tv_round", 128'(out_round), 128'(tv[i].rnd));
            chk("tv_last",  128'(out_last), 128'(tv[i].last));
        end

        y = rnd128();
        send(y, 10, "wrap");

        // Backpressure: output must hold while a new input waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        state_in  = rnd128();
        x         = state_in;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_valid",    128'(out_valid), 128'(1));
            chk("bp_hold",     state_out, y ^ mrk(10));
            chk("bp_round",    128'(out_round), 128'(10));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel_data",  state_out, x ^ mrk(9));
        chk("bp_rel_round", 128'(out_round), 128'(9));
        x = rnd128();
        state_in = x;
        tick();
        in_valid = 1'b0;
        chk("b2b_data",  state_out, x ^ mrk(8));
        chk("b2b_round", 128'(out_round), 128'(8));
        tick();

        key_write(28, 32'hdeadbeef, 1'b0);
        tick();
        key_wr_en = 1'b0;
        chk("busy_wr_err", 128'(key_wr_err), 128'(1));
        tick();
        chk("err_pulse", 128'(key_wr_err), 128'(0));
        send(rnd128(), 7, "after_busy_wr");
        send(rnd128(), 6, "r6");
        send(rnd128(), 5, "r5");

        abort    = 1'b1;
        in_valid = 1'b1;
        state_in = rnd128();
        #1;
        chk("abort_in_ready", 128'(in_ready), 128'(0));
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_valid", 128'(out_valid), 128'(0));

        old_rk10 = mrk(10);
        x = rnd128();
        key_write(40, 32'h01234567, 1'b0);
        in_valid = 1'b1;
        state_in = x;
        tick();
        key_wr_en = 1'b0;
        in_valid  = 1'b0;
        chk("wr_acc_data",  state_out, x ^ old_rk10);
        chk("wr_acc_round", 128'(out_round), 128'(10));
        chk("wr_acc_err",   128'(key_wr_err), 128'(0));
        mk[40] = 32'h01234567;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        key_write(44, 32'hcafef00d, 1'b0);
        tick();
        key_wr_en = 1'b0;
        chk("addr44_err", 128'(key_wr_err), 128'(1));
        send(rnd128(), 10, "new_rk10");
        tick();
        chk("drain_valid", 128'(out_valid), 128'(0));

        model_rc = 9;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            state_in  = rnd128();
            out_ready = ($urandom_range(0, 3) != 0);
            #4;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected", 128'(1), 128'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rand_data",  state_out, e.d);
                    chk("rand_round", 128'(out_round), 128'(e.r));
                    chk("rand_last",  128'(out_last), 128'(e.r == 0));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{state_in ^ mrk(model_rc), model_rc});
                model_rc = (model_rc == 0) ? 10 : model_rc - 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #4;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("rand_unexpected", 128'(1), 128'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rand_tail_data", state_out, e.d);
            end
        end
        tick();
        chk("rand_queue_empty", 128'(q.size()), 128'(0));

        in_valid = 1'b1;
        state_in = rnd128();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_state", state_out, 128'(0));
        chk("mid_rst_round", 128'(out_round), 128'(10));
        chk("mid_rst_last",  128'(out_last), 128'(0));
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 44; i++) mk[i] = '0;
        tick();
        send(rnd128(), 10, "zero_key_r10");
        send(rnd128(), 9,  "zero_key_r9");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/inv_add_round_key_stage.md
# inv_add_round_key_stage

Registered AddRoundKey stage of the iterative AES decryption datapath. It holds the expanded round-key schedule and XORs each incoming 128-bit state with the correct round key, stepping from round NR down to 0. It is the stage directly upstream of the inverse mix-columns logic: it tags each output with its round number so downstream logic routes it to inverse mix-columns (rounds NR-1..1), bypasses it (round NR), or emits plaintext (round 0). It has a valid/ready handshake on both sides and a one-entry output register.

## Interface
- NR, 10, number of cipher rounds; key store holds 4*(NR+1) 32-bit words.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- key_wr_en  input  1  write one key-schedule word this cycle.
- key_wr_addr  input  6  word index w[i], 0..4*NR+3.
- key_wr_data  input  [0:31]  word value; bit 0 is the MSB of byte 0.
- key_wr_err  output  1  one-cycle pulse when a key write is dropped.
- abort  input  1  synchronous flush of the block in flight.
- in_valid  input  1  state_in is valid.
- in_ready  output  1  stage can accept state_in.
- state_in  input  [0:127]  state; byte k is bits 8k..8k+7, column-major as in FIPS-197.
- out_valid  output  1  state_out is valid.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  [0:127]  state_in XOR round key.
- out_round  output  4  round index applied to state_out.
- out_last  output  1  out_round == 0; state_out is plaintext.

## Operation
- Round key r is words w[4r]..w[4r+3], concatenated w[4r] in bits 0:31 through w[4r+3] in bits 96:127.
- Round counter rc, reset value NR. Each accepted input (in_valid && in_ready) uses key rc, then rc decrements. After round 0 is accepted, rc reloads to NR. There is no start pulse: the first state after idle is always round NR.
- Idle means rc == NR and out_valid == 0.
- A key write is performed only when idle and key_wr_addr < 4*NR+4. Otherwise the write is dropped and key_wr_err pulses on the next cycle.
- A key write and an input accept in the same idle cycle: the input uses the old key contents and the write still commits.
- abort has priority over everything else. On the next edge rc = NR and out_valid = 0. Any input presented in the abort cycle is not accepted (in_ready is forced 0). The key store is unaffected.
- out_last is combinational from out_round.

## Timing
- Reset values: out_valid 0, state_out 0, out_round NR, out_last 0, key_wr_err 0, rc NR, all key words 0.
- Latency is 1 cycle from accept to out_valid.
- in_ready = !abort && (!out_valid || out_ready). A full-throughput stream can be accepted back-to-back.
- state_out, out_round and out_last stay stable while out_valid && !out_ready.
- When output is taken and a new input is accepted in the same cycle, the output register reloads with no bubble.
- Reset mid-block returns everything to reset values immediately, including clearing the key store.

## Test plan
- Load the FIPS-197 AES-128 schedule from key 000102030405060708090a0b0c0d0e0f, then present 69c4e0d86a7b0430d8cdb78070b4c55a -> one cycle later state_out = 7ad5fda789ef4e272bca100b3d9ff59f, out_round = 10, out_last = 0.
- Feed the nine intermediate states, then round-0 input 00102030405060708090a0b0c0d0e0f0 -> state_out = 00112233445566778899aabbccddeeff, out_round = 0, out_last = 1; the next accepted input is tagged round 10.
- Hold out_ready low for 3 cycles with in_valid high -> in_ready = 0, output stable, rc unchanged. Release -> back-to-back accepts with no lost or duplicated state.
- Key write attempted at rc = 7, and a write with addr = 44 -> key_wr_err pulses for each write; key contents are unchanged.
- Assert abort at round 5 with out_valid high -> next cycle out_valid = 0. The next input is tagged round 10 and uses rk10.
- Deassert rst_n mid-block -> all outputs are immediately at reset values; state_out for input X after reset equals X (zero keys).
